// File: rtl/operand2_pkg.sv
// Shared definitions for the operand-2 stage: source-select encoding.
package operand2_pkg;

  // Source select carried with each request
  typedef logic [2:0] sel_t;

  localparam sel_t SEL_PB    = 3'b000;  // register-file port B
  localparam sel_t SEL_HI    = 3'b001;  // HI register (forwarded)
  localparam sel_t SEL_LO    = 3'b010;  // LO register (forwarded)
  localparam sel_t SEL_PC    = 3'b011;  // program counter
  localparam sel_t SEL_SEXT  = 3'b100;  // sign-extended immediate
  localparam sel_t SEL_UPPER = 3'b101;  // immediate in the upper bits
  localparam sel_t SEL_ZEXT  = 3'b110;  // zero-extended immediate
  localparam sel_t SEL_LINK  = 3'b111;  // pc + link offset

endpackage

// File: rtl/operand2_fifo.sv
// Two-entry valid/ready buffer. Entry 0 is always the head, so the output
// data is a plain register. in_ready depends only on the stored count.
module operand2_fifo #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_valid,
  output logic              push_ready,
  input  logic [DATA_W-1:0] push_data,
  output logic              pop_valid,
  input  logic              pop_ready,
  output logic [DATA_W-1:0] pop_data
);

  logic [1:0]        count_q, count_d;
  logic [DATA_W-1:0] mem_q [2];
  logic [DATA_W-1:0] mem_d [2];
  logic              push;
  logic              pop;

  assign push_ready = (count_q != 2'd2);
  assign pop_valid  = (count_q != 2'd0);
  assign pop_data   = mem_q[0];
  assign push       = push_valid && push_ready;
  assign pop        = pop_valid && pop_ready;

  // Next-state for count and storage; a pop shifts entry 1 into the head
  always_comb begin
    count_d  = count_q;
    mem_d[0] = mem_q[0];
    mem_d[1] = mem_q[1];
    if (push && pop) begin
      // Only reachable at count 1 (push is blocked at 2, pop at 0):
      // the head leaves and the new entry replaces it.
      mem_d[0] = push_data;
    end else if (pop) begin
      mem_d[0] = mem_q[1];
      count_d  = count_q - 2'd1;
    end else if (push) begin
      // count is 0 or 1 here, so its low bit names the free slot
      mem_d[count_q[0]] = push_data;
      count_d           = count_q + 2'd1;
    end
  end

  // Storage and occupancy registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= 2'd0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else begin
      count_q  <= count_d;
      mem_q[0] <= mem_d[0];
      mem_q[1] <= mem_d[1];
    end
  end

endmodule

// File: rtl/operand2_stage.sv
// Operand-2 stage: owns HI/LO, forwards same-cycle HI/LO writes into the
// source select, and buffers results in a 2-entry output FIFO.
module operand2_stage
  import operand2_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int IMM_W       = 16,
  parameter int LINK_OFFSET = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        sel,
  input  logic [DATA_W-1:0] pb,
  input  logic [DATA_W-1:0] pc,
  input  logic [IMM_W-1:0]  imm,
  input  logic              hi_we,
  input  logic              lo_we,
  input  logic [DATA_W-1:0] hi_wdata,
  input  logic [DATA_W-1:0] lo_wdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] n,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;
  logic [DATA_W-1:0] operand;
  sel_t              sel_s;

  assign sel_s = sel_t'(sel);
  assign hi    = hi_q;
  assign lo    = lo_q;

  // HI/LO next value; also serves as the forwarded value for the select
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (hi_we) hi_d = hi_wdata;
    if (lo_we) lo_d = lo_wdata;
  end

  // HI/LO registers update on every write-enable edge, regardless of requests
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  // Source select; size casts make the immediate forms collapse to imm
  // unchanged when IMM_W == DATA_W
  always_comb begin
    operand = '0;
    case (sel_s)
      SEL_PB:    operand = pb;
      SEL_HI:    operand = hi_d;
      SEL_LO:    operand = lo_d;
      SEL_PC:    operand = pc;
      SEL_SEXT:  operand = DATA_W'($signed(imm));
      SEL_UPPER: operand = DATA_W'(imm) << (DATA_W - IMM_W);
      SEL_ZEXT:  operand = DATA_W'(imm);
      SEL_LINK:  operand = pc + DATA_W'(LINK_OFFSET);
      default:   operand = '0;
    endcase
  end

  operand2_fifo #(
    .DATA_W(DATA_W)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_valid (in_valid),
    .push_ready (in_ready),
    .push_data  (operand),
    .pop_valid  (out_valid),
    .pop_ready  (out_ready),
    .pop_data   (n)
  );

endmodule

// File: tb/tb_operand2_stage.sv
// Directed bench for operand2_stage with a small reference model for the
// random-select throughput run.
module tb_operand2_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  sel;
  logic [31:0] pb;
  logic [31:0] pc;
  logic [15:0] imm;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] hi_wdata;
  logic [31:0] lo_wdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] n;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_vec;
  int n_miscmp;

  operand2_stage #(
    .DATA_W(32),
    .IMM_W(16),
    .LINK_OFFSET(8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sel       (sel),
    .pb        (pb),
    .pc        (pc),
    .imm       (imm),
    .hi_we     (hi_we),
    .lo_we     (lo_we),
    .hi_wdata  (hi_wdata),
    .lo_wdata  (lo_wdata),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .n         (n),
    .hi        (hi),
    .lo        (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  // Advance one clock edge and settle past it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] m_hi, m_lo, m_exp;

  initial begin
    n_vec    = 0;
    n_miscmp = 0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    sel      = 3'd0;
    pb       = '0;
    pc       = '0;
    imm      = '0;
    hi_we    = 1'b0;
    lo_we    = 1'b0;
    hi_wdata = '0;
    lo_wdata = '0;
    out_ready = 1'b1;

    // Reset state
    #2;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_n_val",     n,  32'd0);
    check("rst_hi",        hi, 32'd0);
    check("rst_lo",        lo, 32'd0);
    step(); step();
    rst_n = 1'b1;
    step();
    check("idle_out_valid", 32'(out_valid), 32'd0);

    // Immediate forms and link address, with out_ready high
    in_valid = 1'b1; sel = 3'b100; imm = 16'h8001;
    step();
    check("sext_n",     n, 32'hFFFF8001);
    check("sext_valid", 32'(out_valid), 32'd1);
    sel = 3'b101; imm = 16'h1234;
    step();
    check("upper_n", n, 32'h12340000);
    sel = 3'b110; imm = 16'h8001;
    step();
    check("zext_n", n, 32'h00008001);
    sel = 3'b111; pc = 32'hFFFFFFFC;
    step();
    check("link_wrap_n", n, 32'h00000004);
    sel = 3'b011; pc = 32'h00400010;
    step();
    check("pc_n", n, 32'h00400010);

    // HI/LO forwarding in the accepting cycle
    sel = 3'b001; hi_we = 1'b1; hi_wdata = 32'hA5A5A5A5;
    step();
    check("fwd_hi_n", n,  32'hA5A5A5A5);
    check("fwd_hi_reg", hi, 32'hA5A5A5A5);
    hi_we = 1'b0;
    sel = 3'b010; lo_we = 1'b1; lo_wdata = 32'h5A5A0F0F;
    step();
    check("fwd_lo_n",  n,  32'h5A5A0F0F);
    check("fwd_lo_reg", lo, 32'h5A5A0F0F);
    lo_we = 1'b0;
    sel = 3'b001;
    step();
    check("hi_stored_n", n, 32'hA5A5A5A5);

    // HI writes without a request; buffer drains
    in_valid = 1'b0; hi_we = 1'b1; hi_wdata = 32'h00000011;
    step();
    hi_we = 1'b0;
    check("hi_no_req", hi, 32'h00000011);
    check("drain_valid", 32'(out_valid), 32'd0);

    // Back-pressure: three requests into a 2-entry buffer
    out_ready = 1'b0; in_valid = 1'b1; sel = 3'b000; pb = 32'd1;
    step();
    check("bp_ready_1", 32'(in_ready), 32'd1);
    pb = 32'd2;
    step();
    check("bp_ready_2", 32'(in_ready), 32'd0);
    pb = 32'd3;
    step();
    check("bp_ready_held", 32'(in_ready), 32'd0);
    check("bp_head", n, 32'd1);
    out_ready = 1'b1;
    step();
    check("bp_seq_2", n, 32'd2);
    step();
    check("bp_seq_3", n, 32'd3);
    in_valid = 1'b0;
    step();
    check("bp_empty", 32'(out_valid), 32'd0);

    // Continuous random selects against a reference model
    m_hi = hi;
    m_lo = lo;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      sel      = 3'($urandom_range(0, 7));
      pb       = $urandom;
      pc       = $urandom;
      imm      = 16'($urandom);
      hi_we    = 1'($urandom);
      lo_we    = 1'($urandom);
      hi_wdata = $urandom;
      lo_wdata = $urandom;
      if (hi_we) m_hi = hi_wdata;
      if (lo_we) m_lo = lo_wdata;
      case (sel)
        3'b000:  m_exp = pb;
        3'b001:  m_exp = m_hi;
        3'b010:  m_exp = m_lo;
        3'b011:  m_exp = pc;
        3'b100:  m_exp = {{16{imm[15]}}, imm};
        3'b101:  m_exp = {imm, 16'h0000};
        3'b110:  m_exp = {16'h0000, imm};
        default: m_exp = pc + 32'd8;
      endcase
      step();
      check($sformatf("rand_%0d_sel%0d", i, sel), n, m_exp);
      if (out_valid !== 1'b1) check("rand_valid", 32'(out_valid), 32'd1);
    end
    check("rand_hi", hi, m_hi);
    check("rand_lo", lo, m_lo);
    hi_we = 1'b0; lo_we = 1'b0;

    // Reset while the buffer is full
    out_ready = 1'b0; sel = 3'b000; pb = 32'hDEAD0001;
    step();
    pb = 32'hDEAD0002;
    step();
    check("pre_rst_ready", 32'(in_ready), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_ready", 32'(in_ready),  32'd1);
    check("mid_rst_hi",    hi, 32'd0);
    check("mid_rst_lo",    lo, 32'd0);
    check("mid_rst_n",     n,  32'd0);
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    rst_n = 1'b1;
    step(); step();
    check("post_rst_valid", 32'(out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/operand2_stage.md
# operand2_stage

Registered, parametrised operand-2 stage for the execute datapath. Each accepted request selects one of eight sources: PB, HI, LO, PC, link address, and three immediate forms. The block owns the HI/LO register pair, forwards same-cycle HI/LO writes, and delivers results through a 2-entry valid/ready output buffer. This lets the operand path stall independently of decode.

## Interface
Parameters:
- DATA_W, 32, datapath width.
- IMM_W, 16, immediate width; legal range 1..DATA_W.
- LINK_OFFSET, 8, constant added to PC for the link-address mode.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- in_valid  in  1  request present.
- in_ready  out  1  stage can accept a request.
- sel  in  3  source select; see Operation.
- pb  in  DATA_W  register-file port B.
- pc  in  DATA_W  program counter of the request.
- imm  in  IMM_W  instruction immediate.
- hi_we  in  1  write HI this cycle.
- lo_we  in  1  write LO this cycle.
- hi_wdata  in  DATA_W  HI write data from mult/div.
- lo_wdata  in  DATA_W  LO write data from mult/div.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- n  out  DATA_W  selected operand; head of buffer.
- hi  out  DATA_W  current HI register.
- lo  out  DATA_W  current LO register.

## Operation
- A request is accepted on a rising edge when in_valid && in_ready.
- Source encoding, evaluated at acceptance:
  - 000 → pb.
  - 001 → HI.
  - 010 → LO.
  - 011 → pc.
  - 100 → sign-extended imm.
  - 101 → imm in the upper IMM_W bits, lower bits zero.
  - 110 → zero-extended imm.
  - 111 → pc + LINK_OFFSET, modulo 2^DATA_W.
- All eight codes are defined. There is no default or garbage output.
- When IMM_W == DATA_W, modes 100/101/110 all yield imm unchanged.
- HI/LO forwarding: if hi_we is high in the accepting cycle, mode 001 captures hi_wdata, not the old HI. LO behaves the same way with lo_we.
- HI/LO update on every edge their write enable is high, independent of in_valid.
- Output buffer is a 2-entry FIFO, with count in 0..2.
  - in_ready = (count != 2). It depends on count only, with no combinational path from out_ready.
  - out_valid = (count != 0).
  - n = head entry.
  - Push and pop in the same cycle: count unchanged, order preserved.
  - Pop at count 0 cannot happen, since out_valid is low.
  - At count 2, in_valid is ignored and the request must be held by the producer.
  - Holding the same request across stall cycles re-evaluates sel at the eventual accept edge, including forwarding.
- States are implied by count: EMPTY (0), ONE (1), FULL (2).
  - EMPTY → ONE on push.
  - ONE → FULL on push without pop.
  - ONE → EMPTY on pop without push.
  - FULL → ONE on pop.

## Timing
- Reset values: out_valid=0, n=0, hi=0, lo=0, count=0. in_ready=1 while rst_n is low and after release.
- Latency: a request accepted at edge k is visible on n with out_valid=1 after edge k, provided the buffer was empty.
- Throughput: one result per cycle with out_ready held high.
- hi/lo outputs reflect a write one edge after hi_we/lo_we.
- Reset asserted mid-operation clears buffered entries and HI/LO immediately. No result is emitted after reset release until a new accept.

## Structure
- Package operand2_pkg:
  - SEL_PB, SEL_HI, SEL_LO, SEL_PC, SEL_SEXT, SEL_UPPER, SEL_ZEXT, SEL_LINK as 3-bit localparams.
  - The sel_t typedef.
- Sub-module operand2_fifo: parametrised 2-entry FIFO (DATA_W), owning count, in_ready, out_valid and head data.
- The top level owns the HI/LO registers, the forwarding muxes and the source select.

## Test plan
- Reset release, then sel=100, imm=16'h8001 → one cycle later n=32'hFFFF8001, out_valid=1.
- sel=101, imm=16'h1234 → n=32'h12340000. sel=110, imm=16'h8001 → n=32'h00008001. sel=111, pc=32'hFFFFFFFC → n=32'h00000004 (wrap).
- hi_we=1, hi_wdata=32'hA5A5A5A5 in the same cycle as an accept with sel=001 → n=32'hA5A5A5A5; hi=32'hA5A5A5A5 on the next cycle.
- out_ready=0, three back-to-back requests with pb=1,2,3 → in_ready drops after 2 accepts. Raise out_ready → n sequence 1, 2, 3 with no loss or duplication.
- Continuous in_valid/out_ready for 100 cycles with random sel → one result per cycle matching a reference model.
- Assert rst_n low with count=2 → out_valid=0, hi=lo=0 immediately, in_ready=1. No stale result after release.
